// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: bus-programmed scan controller for a 4-digit multiplexed seven-segment display.
// Define DISP_LZB_EN to compile in leading-zero blanking (CTRL bit1).
module disp_scan_ctrl #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              we,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic [7:0]        Disp,
  output logic [3:0]        Disp_sel
);

  localparam int unsigned CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - BLANK_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_e;

  // Bus-visible registers
  logic [15:0] digits_q;
  logic [3:0]  dp_q;
  logic [3:0]  en_q;
  logic        run_q;
  logic        lzb_q;

  // Frame shadow copies
  logic [15:0] sh_digits_q;
  logic [3:0]  sh_dp_q;
  logic [3:0]  sh_en_q;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             load_c;
  logic [7:0]       disp_q, disp_d;
  logic [3:0]       sel_q, sel_d;
  logic [3:0]       nib_c;
  logic [3:0]       lz_mask_c;
  logic             wr_en_c;

  assign wr_en_c = sel & we;

  generate
    if (DATA_W > 16) begin : g_unused
      logic unused_hi;
      assign unused_hi = ^data_in[DATA_W-1:16];
    end
  endgenerate

  // Active-low a..g pattern for one hex nibble
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Register file writes
  always_ff @(posedge clk) begin
    if (rst) begin
      digits_q <= 16'h0000;
      dp_q     <= 4'h0;
      en_q     <= 4'h0;
      run_q    <= 1'b0;
    end else if (wr_en_c) begin
      case (addr)
        2'd0: digits_q <= data_in[15:0];
        2'd1: dp_q     <= data_in[3:0];
        2'd2: en_q     <= data_in[3:0];
        default: run_q <= data_in[0];
      endcase
    end
  end

`ifdef DISP_LZB_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      lzb_q <= 1'b0;
    end else if (wr_en_c && (addr == 2'd3)) begin
      lzb_q <= data_in[1];
    end
  end

  // A digit is blanked when it and every digit to its left are zero
  logic z3_c, z2_c, z1_c;
  assign z3_c = (sh_digits_q[15:12] == 4'h0);
  assign z2_c = (sh_digits_q[11:8] == 4'h0);
  assign z1_c = (sh_digits_q[7:4] == 4'h0);
  assign lz_mask_c = lzb_q ? {z3_c, z3_c & z2_c, z3_c & z2_c & z1_c, 1'b0} : 4'h0;
`else
  assign lzb_q     = 1'b0;
  assign lz_mask_c = 4'h0;
`endif

  always_comb begin
    data_out = '0;
    case (addr)
      2'd0: data_out = DATA_W'(digits_q);
      2'd1: data_out = DATA_W'(dp_q);
      2'd2: data_out = DATA_W'(en_q);
      default: data_out = DATA_W'({lzb_q, run_q});
    endcase
  end

  // Scan sequencing and next output values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    load_c  = 1'b0;
    disp_d  = 8'hFF;
    sel_d   = 4'hF;
    nib_c   = 4'h0;

    case (state_q)
      ST_IDLE: begin
        if (run_q) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          idx_d   = 2'd0;
          load_c  = 1'b1;
        end
      end
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          idx_d   = idx_q + 2'd1;
          load_c  = (idx_q == 2'd3);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        idx_d   = 2'd0;
      end
    endcase

    // Clearing RUN wins over every other transition
    if (!run_q) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = 2'd0;
      load_c  = 1'b0;
    end

    nib_c = sh_digits_q[{idx_d, 2'b00} +: 4];
    if ((state_d == ST_SHOW) && sh_en_q[idx_d]) begin
      sel_d = ~(4'b0001 << idx_d);
      if (!lz_mask_c[idx_d]) begin
        disp_d = {~sh_dp_q[idx_d], seg7(nib_c)};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= 2'd0;
      sh_digits_q <= 16'h0000;
      sh_dp_q     <= 4'h0;
      sh_en_q     <= 4'h0;
      disp_q      <= 8'hFF;
      sel_q       <= 4'hF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      disp_q  <= disp_d;
      sel_q   <= sel_d;
      if (load_c) begin
        sh_digits_q <= digits_q;
        sh_dp_q     <= dp_q;
        sh_en_q     <= en_q;
      end
    end
  end

  assign Disp     = disp_q;
  assign Disp_sel = sel_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: vector table, hand sequences and random bus traffic vs a time-based model.
// Expectations for CTRL bit1 follow DISP_LZB_EN when defined.
module tb_disp_scan_ctrl;

  localparam int unsigned SD    = 8;
  localparam int unsigned BC    = 2;
  localparam int unsigned FRAME = 4 * SD;

  logic        clk = 1'b0;
  logic        rst, sel, we;
  logic [1:0]  addr;
  logic [31:0] data_in, data_out;
  logic [7:0]  Disp;
  logic [3:0]  Disp_sel;

  int total = 0;
  int bad   = 0;

  disp_scan_ctrl #(.DATA_W(32), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr),
    .data_in(data_in), .data_out(data_out), .Disp(Disp), .Disp_sel(Disp_sel)
  );

  always #5 clk = ~clk;

  // Reference model: display content is a function of cycles elapsed since RUN took effect
  logic [7:0]  hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [15:0] m_digits = 0, sh_digits = 0;
  logic [3:0]  m_dp = 0, m_en = 0, sh_dp = 0, sh_en = 0, exp_sel = 4'hF;
  logic        m_run = 0, m_lzb = 0, m_running = 0, m_valid = 0, lzb_old;
  logic [7:0]  exp_disp = 8'hFF;
  logic [3:0]  nib;
  int          m_t = 0, m_idx, m_off;

  always @(posedge clk) begin
    lzb_old = m_lzb;
    if (rst) begin
      m_digits = 0; m_dp = 0; m_en = 0; m_run = 0; m_lzb = 0;
      m_running = 0; exp_disp = 8'hFF; exp_sel = 4'hF; m_valid = 1;
    end else begin
      if (!m_run) begin
        m_running = 0;
      end else if (!m_running) begin
        m_running = 1; m_t = 0;
        sh_digits = m_digits; sh_dp = m_dp; sh_en = m_en;
      end else begin
        m_t = (m_t + 1) % FRAME;
        if (m_t == 0) begin
          sh_digits = m_digits; sh_dp = m_dp; sh_en = m_en;
        end
      end
      exp_disp = 8'hFF;
      exp_sel  = 4'hF;
      if (m_running) begin
        m_idx = m_t / SD;
        m_off = m_t % SD;
        if (m_off >= BC && sh_en[m_idx]) begin
          exp_sel = ~4'(1 << m_idx);
          nib = 4'(sh_digits >> (4 * m_idx));
          if (!(lzb_old && m_idx > 0 && (sh_digits >> (4 * m_idx)) == 0))
            exp_disp = {~sh_dp[m_idx], hex_tab[nib][6:0]};
        end
      end
      if (sel && we) begin
        case (addr)
          2'd0: m_digits = data_in[15:0];
          2'd1: m_dp = data_in[3:0];
          2'd2: m_en = data_in[3:0];
          default: begin
            m_run = data_in[0];
`ifdef DISP_LZB_EN
            m_lzb = data_in[1];
`endif
          end
        endcase
      end
    end
  end

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    case (a)
      2'd0: return {16'h0, m_digits};
      2'd1: return {28'h0, m_dp};
      2'd2: return {28'h0, m_en};
      default: return {30'h0, m_lzb, m_run};
    endcase
  endfunction

  // Continuous comparison against the model
  always @(negedge clk) begin
    if (m_valid) begin
      total++;
      if (Disp !== exp_disp || Disp_sel !== exp_sel) begin
        bad++;
        $display("FAIL scan @%0t: Disp=%h Disp_sel=%h, want %h/%h", $time, Disp, Disp_sel, exp_disp, exp_sel);
      end
      total++;
      if (data_out !== exp_rd(addr)) begin
        bad++;
        $display("FAIL readback @%0t addr=%0d: got %h, want %h", $time, addr, data_out, exp_rd(addr));
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1; sel = 0; we = 0;
    @(negedge clk); @(negedge clk); #1;
    rst = 0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk); #1;
    sel = 1; we = 1; addr = a; data_in = d;
    @(negedge clk); #1;
    sel = 0; we = 0;
  endtask

  // Wait for a lit sample inside digit slot k; timing taken from the model
  task automatic wait_slot(input int k);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(m_running && (m_t / SD) == k && (m_t % SD) == BC + 1) && n < 200);
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL wait_slot %0d: timed out", k);
    end
  endtask

  typedef struct {
    logic [15:0]      digits;
    logic [3:0]       dp;
    logic [3:0]       en;
    logic [1:0]       ctrl;
    logic [3:0][7:0]  disp;
    logic [3:0][3:0]  dsel;
  } vec_t;

  vec_t vecs [8];

  initial begin
    rst = 1; sel = 0; we = 0; addr = 0; data_in = 0;
    vecs[0] = '{16'h4A10, 4'h0, 4'hF, 2'd1, {8'h99, 8'h88, 8'hF9, 8'hC0}, {4'h7, 4'hB, 4'hD, 4'hE}};
    vecs[1] = '{16'h8888, 4'h1, 4'h5, 2'd1, {8'hFF, 8'h80, 8'hFF, 8'h00}, {4'hF, 4'hB, 4'hF, 4'hE}};
    vecs[2] = '{16'h3210, 4'hA, 4'hF, 2'd1, {8'h30, 8'hA4, 8'h79, 8'hC0}, {4'h7, 4'hB, 4'hD, 4'hE}};
    vecs[3] = '{16'h7654, 4'h0, 4'hF, 2'd1, {8'hF8, 8'h82, 8'h92, 8'h99}, {4'h7, 4'hB, 4'hD, 4'hE}};
    vecs[4] = '{16'hBA98, 4'h5, 4'hF, 2'd1, {8'h83, 8'h08, 8'h90, 8'h00}, {4'h7, 4'hB, 4'hD, 4'hE}};
    vecs[5] = '{16'hFEDC, 4'h0, 4'hF, 2'd1, {8'h8E, 8'h86, 8'hA1, 8'hC6}, {4'h7, 4'hB, 4'hD, 4'hE}};
`ifdef DISP_LZB_EN
    vecs[6] = '{16'h0050, 4'h0, 4'hF, 2'd3, {8'hFF, 8'hFF, 8'h92, 8'hC0}, {4'h7, 4'hB, 4'hD, 4'hE}};
    vecs[7] = '{16'h0000, 4'hF, 4'hF, 2'd3, {8'hFF, 8'hFF, 8'hFF, 8'h40}, {4'h7, 4'hB, 4'hD, 4'hE}};
`else
    vecs[6] = '{16'h0050, 4'h0, 4'hF, 2'd3, {8'hC0, 8'hC0, 8'h92, 8'hC0}, {4'h7, 4'hB, 4'hD, 4'hE}};
    vecs[7] = '{16'h0000, 4'hF, 4'hF, 2'd3, {8'h40, 8'h40, 8'h40, 8'h40}, {4'h7, 4'hB, 4'hD, 4'hE}};
`endif

    // Reset state
    @(negedge clk); @(negedge clk); #1;
    rst = 0;
    check("reset Disp", 32'(Disp), 32'hFF);
    check("reset Disp_sel", 32'(Disp_sel), 32'hF);
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a); #1;
      check("reset reg", data_out, 32'h0);
    end
    addr = 0;

    // Vector table
    for (int v = 0; v < 8; v++) begin
      do_reset();
      wr(2'd0, {16'hDEAD, vecs[v].digits});
      wr(2'd1, {28'hFFFFFF0, vecs[v].dp});
      wr(2'd2, {28'h0, vecs[v].en});
      wr(2'd3, {30'h0, vecs[v].ctrl});
      addr = 2'd0; #1; check("rd DIGITS", data_out, {16'h0, vecs[v].digits});
      addr = 2'd1; #1; check("rd DP", data_out, {28'h0, vecs[v].dp});
      addr = 2'd2; #1; check("rd EN", data_out, {28'h0, vecs[v].en});
      addr = 2'd3; #1;
`ifdef DISP_LZB_EN
      check("rd CTRL", data_out, {30'h0, vecs[v].ctrl});
`else
      check("rd CTRL", data_out, {31'h0, vecs[v].ctrl[0]});
`endif
      addr = 2'd0;
      for (int k = 0; k < 4; k++) begin
        wait_slot(k);
        check($sformatf("vec%0d Disp d%0d", v, k), 32'(Disp), 32'(vecs[v].disp[k]));
        check($sformatf("vec%0d sel d%0d", v, k), 32'(Disp_sel), 32'(vecs[v].dsel[k]));
      end
    end

    // Double buffering: a write mid-frame only shows from the next frame
    do_reset();
    wr(2'd0, 32'h4A10); wr(2'd2, 32'hF); wr(2'd3, 32'h1);
    wait_slot(2);
    wr(2'd0, 32'h1234);
    check("dbuf d2 held", 32'(Disp), 32'h88);
    wait_slot(3); check("dbuf d3 held", 32'(Disp), 32'h99);
    wait_slot(0); check("dbuf new d0", 32'(Disp), 32'h99);
    wait_slot(1); check("dbuf new d1", 32'(Disp), 32'hB0);
    wait_slot(2); check("dbuf new d2", 32'(Disp), 32'hA4);
    wait_slot(3); check("dbuf new d3", {24'h0, Disp, Disp_sel}, 32'hF97);

    // Stop mid-scan and restart from digit 0
    wait_slot(1);
    wr(2'd3, 32'h0);
    @(negedge clk);
    check("stop off", {24'h0, Disp, Disp_sel}, 32'hFFF);
    repeat (3) @(negedge clk);
    check("stop idle", {24'h0, Disp, Disp_sel}, 32'hFFF);
    wr(2'd3, 32'h1);
    check("restart pending", {24'h0, Disp, Disp_sel}, 32'hFFF);
    @(negedge clk); check("restart blank0", {24'h0, Disp, Disp_sel}, 32'hFFF);
    @(negedge clk); check("restart blank1", {24'h0, Disp, Disp_sel}, 32'hFFF);
    @(negedge clk); check("restart d0", {24'h0, Disp, Disp_sel}, 32'h99E);

    // Random bus traffic against the model
    do_reset();
    wr(2'd2, 32'hF); wr(2'd3, 32'h1);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      rst     = ($urandom_range(0, 999) == 0);
      sel     = ($urandom_range(0, 7) == 0);
      we      = 1'($urandom_range(0, 1));
      addr    = 2'($urandom_range(0, 3));
      data_in = $urandom;
      if (addr == 2'd0 && $urandom_range(0, 1) == 1) data_in = data_in & 32'hFF;
      if (addr == 2'd3) data_in[0] = ($urandom_range(0, 15) != 0);
    end
    @(negedge clk); #1;
    rst = 0; sel = 0; we = 0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
Memory-mapped scan controller for the 4-digit multiplexed seven-segment display on the board.
- picoVersat writes digit values, decimal points, digit enables and control through the peripheral bus.
- The block time-multiplexes the digits onto Disp/Disp_sel, inserting a blanking gap between digits to prevent ghosting.
- Digit data is double-buffered so a frame never shows a half-updated value.
- It sits between the picoVersat data bus and the top-level Disp/Disp_sel pins.

Parameters:
DATA_W, 32, bus data width
SCAN_DIV, 50000, clock cycles per digit slot (blank plus show); must be > BLANK_CYC
BLANK_CYC, 16, all-off cycles at the start of each slot; must be >= 1

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
sel  in  1  peripheral select
we  in  1  write enable, qualified by sel
addr  in  2  register address
data_in  in  DATA_W  write data
data_out  out  DATA_W  read data; combinational from addr, zero-extended
Disp  out  8  segments, active-low; bit0=a … bit6=g, bit7=dp
Disp_sel  out  4  digit anodes, active-low; bit0 = rightmost digit

Behaviour:
- Registers:
  - addr0 DIGITS[15:0]: nibble k holds the value of digit k.
  - addr1 DP[3:0]: decimal point per digit.
  - addr2 EN[3:0]: digit enable.
  - addr3 CTRL: bit0 RUN, bit1 LZB (see Optional Feature).
  - Unused bits read 0. Writes occur on an edge with sel&we.
- Reset values:
  - All registers are 0 and the state is IDLE.
  - Disp=8'hFF, Disp_sel=4'hF, data_out=0 (addr=0).
  - Reset mid-scan returns to this condition on the next edge.
- Shadow copies of DIGITS/DP/EN drive the display.
  - They are loaded when entering slot 0 (idx=0): from IDLE, and on each wrap from idx 3 to 0.
  - A register write on the same edge as a shadow load is not captured by the shadow; it is displayed from the next frame.
- FSM states: IDLE, BLANK, SHOW. Counter cnt, digit index idx[1:0].
  - IDLE: outputs all off. If RUN=1 → BLANK with idx=0, cnt=0, shadow load.
  - BLANK: outputs all off. At cnt==BLANK_CYC-1 → SHOW, cnt=0.
  - SHOW: at cnt==SCAN_DIV-BLANK_CYC-1 → BLANK, cnt=0, idx=idx+1 (3 wraps to 0, with shadow load).
  - Any state with RUN=0 → IDLE on the next edge, which overrides other transitions.
- Outputs are registered and change on the same edge as the state transition.
  - In SHOW: Disp_sel = ~(1<<idx).
  - Disp = {~dp[idx], ~seg(nibble idx)}.
  - If en[idx]=0, SHOW drives Disp=8'hFF and Disp_sel=4'hF, but keeps the same timing.
- Hex decode (Disp including dp off):
  - 0→C0, 1→F9, 2→A4, 3→B0, 4→99, 5→92, 6→82, 7→F8
  - 8→80, 9→90, A→88, b→83, C→C6, d→A1, E→86, F→8E
- Frame period is 4*SCAN_DIV cycles. Each digit is lit for SCAN_DIV-BLANK_CYC cycles.

Optional Feature:
DISP_LZB_EN. Compiled in:
- CTRL bit1 is writable and readable.
- When CTRL[1]=1, digit k (k=3..1) is blanked (Disp=8'hFF in its SHOW slot) if its shadow nibble and all higher shadow nibbles are 0.
- Digit 0 is never blanked by LZB.
- The dp of a blanked digit is also suppressed.

Compiled out:
- CTRL bit1 ignores writes and reads 0.
- No leading-zero blanking.

Test Plan:
- Reset state: hold rst=1 for 2 cycles with SCAN_DIV=8, BLANK_CYC=2 → Disp=FF, Disp_sel=F, all registers read 0.
- Basic scan:
  - Stimulus: DIGITS=16'h4A10, EN=F, DP=0, then CTRL=1.
  - Required response: each slot gives 2 cycles of FF/F, then 6 cycles of digit 0 C0/E, then blank, then digit 1 F9/D, then digit 2 88/B, then digit 3 99/7, then repeat.
- Double buffering: during the digit-2 SHOW slot, write DIGITS=16'h1234 → remainder of the frame still shows A and 4; the next frame shows 4,3,2,1 on digits 0..3.
- Enable and dp:
  - Stimulus: EN=4'b0101, DP=4'b0001, DIGITS=16'h8888.
  - Required response: digit 0 shows 00 with Disp_sel E; digit 2 shows 80; the digit 1 and 3 slots show FF/F with unchanged slot timing.
- Stop mid-scan: write CTRL=0 during SHOW → next edge gives FF/F and IDLE; a rewrite of CTRL=1 restarts at digit 0 with a BLANK slot.
- LZB (with DISP_LZB_EN): DIGITS=16'h0050, CTRL=3 → digits 3 and 2 blanked (FF), digit 1 shows 92, digit 0 shows C0; with DIGITS=0, only digit 0 shows C0.
